// File: rtl/ts_bus_pkg.sv
// Shared types and helpers for the Turbosound-FM bus initiator.
package ts_bus_pkg;

   typedef enum logic [1:0] {
      OP_SEL  = 2'd0,
      OP_WR   = 2'd1,
      OP_RD   = 2'd2,
      OP_STAT = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEL  = 3'd1,
      ST_ADDR = 3'd2,
      ST_WR   = 3'd3,
      ST_RD   = 3'd4,
      ST_GAP  = 3'd5,
      ST_RSP  = 3'd6
   } state_e;

   // Address prefix the responder decodes as a chip-select write.
   localparam logic [4:0] SEL_PREFIX = 5'b11111;

   typedef struct packed {
      op_e        op;
      logic       chip;
      logic [7:0] addr;
      logic [7:0] data;
   } cmd_t;

   // Register accesses whose address would alias onto the select decode.
   function automatic logic is_rejected(input op_e op, input logic [4:0] addr_hi);
      return ((op == OP_WR) || (op == OP_RD)) && (addr_hi == SEL_PREFIX);
   endfunction

   // Select word: fm enable is active-low on the wire.
   function automatic logic [7:0] sel_word(input logic fm, input logic stat, input logic chip);
      return {SEL_PREFIX, ~fm, stat, chip};
   endfunction

endpackage

// File: rtl/ts_cmd_fifo.sv
// Command FIFO; a push into a full FIFO is accepted only when a pop
// frees the slot in the same cycle.
module ts_cmd_fifo
   import ts_bus_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  cmd_t din,
   input  logic pop,
   output cmd_t dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);

   cmd_t          mem [DEPTH];
   logic [AW:0]   wr_ptr_r;
   logic [AW:0]   rd_ptr_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);
   assign dout      = mem[rd_ptr_r[AW-1:0]];

   // Read/write pointers; reset empties the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
   end

   // Entry storage, no reset needed (guarded by the pointers).
   always_ff @(posedge clk) begin
      if (do_push_s) mem[wr_ptr_r[AW-1:0]] <= din;
   end

endmodule

// File: rtl/turbosound_bus_master.sv
// Turbosound-FM bus initiator: replays queued select/write/read commands
// as BDIR/BC bus phases paced on CE_CPU, inserting chip selects as needed.
module turbosound_bus_master
   import ts_bus_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int HOLD_CE    = 2
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       CE_CPU,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   input  logic [1:0] CMD_OP,
   input  logic       CMD_CHIP,
   input  logic [7:0] CMD_ADDR,
   input  logic [7:0] CMD_DATA,
   output logic       RSP_VALID,
   output logic [7:0] RSP_DATA,
   output logic       ERR,
   output logic       BUSY,
   output logic       BDIR,
   output logic       BC,
   output logic [7:0] BUS_DO,
   input  logic [7:0] BUS_DI
);
   localparam int CW = (HOLD_CE > 1) ? $clog2(HOLD_CE) : 1;
   localparam logic [CW-1:0] LAST_TICK = CW'(HOLD_CE - 1);

   state_e        state_r, state_n;
   state_e        prev_r, prev_n;
   cmd_t          cmd_r, cmd_n, head_s, cmd_in_s;
   logic [CW-1:0] cnt_r, cnt_n;
   logic [7:0]    bus_do_r, bus_do_n;
   logic [7:0]    rsp_data_r, rsp_data_n;
   logic          cur_chip_r, cur_chip_n;
   logic          cur_stat_r, cur_stat_n;
   logic          cur_fm_r, cur_fm_n;
   logic          rsp_valid_r, rsp_valid_n;
   logic          err_r, err_n;
   logic          bdir_r, bc_r;
   logic          pop_s, push_s, full_s, empty_s;

   // Pack the incoming command fields.
   always_comb begin
      cmd_in_s.op   = op_e'(CMD_OP);
      cmd_in_s.chip = CMD_CHIP;
      cmd_in_s.addr = CMD_ADDR;
      cmd_in_s.data = CMD_DATA;
   end

   assign CMD_READY = ~full_s | pop_s;
   assign push_s    = CMD_VALID & CMD_READY;

   ts_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (CLK),
      .rst_n (RESET_N),
      .push  (push_s),
      .din   (cmd_in_s),
      .pop   (pop_s),
      .dout  (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Next-state, bus word, shadow and response decode.
   always_comb begin
      state_n     = state_r;
      prev_n      = prev_r;
      cmd_n       = cmd_r;
      cnt_n       = cnt_r;
      bus_do_n    = bus_do_r;
      rsp_data_n  = rsp_data_r;
      cur_chip_n  = cur_chip_r;
      cur_stat_n  = cur_stat_r;
      cur_fm_n    = cur_fm_r;
      rsp_valid_n = 1'b0;
      err_n       = 1'b0;
      pop_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!empty_s) begin
               pop_s = 1'b1;
               cmd_n = head_s;
               cnt_n = '0;
               if (is_rejected(head_s.op, head_s.addr[7:3])) begin
                  err_n = 1'b1;
               end else if (head_s.op == OP_SEL) begin
                  state_n  = ST_SEL;
                  bus_do_n = sel_word(head_s.data[1], head_s.data[0], head_s.chip);
               end else if (head_s.chip != cur_chip_r) begin
                  state_n  = ST_SEL;
                  bus_do_n = sel_word(cur_fm_r, cur_stat_r, head_s.chip);
               end else if (head_s.op == OP_STAT) begin
                  state_n = ST_RD;
               end else begin
                  state_n  = ST_ADDR;
                  bus_do_n = head_s.addr;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_SEL, ST_ADDR, ST_WR, ST_RD: begin
            if (CE_CPU) begin
               if (cnt_r == LAST_TICK) begin
                  state_n = ST_GAP;
                  prev_n  = state_r;
                  cnt_n   = '0;
                  if (state_r == ST_SEL) begin
                     // The select word already carries the new shadow values.
                     cur_chip_n = cmd_r.chip;
                     cur_stat_n = bus_do_r[1];
                     cur_fm_n   = ~bus_do_r[2];
                  end else if (state_r == ST_RD) begin
                     rsp_data_n = BUS_DI;
                  end else begin
                     cnt_n = '0;
                  end
               end else begin
                  cnt_n = cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end else begin
               cnt_n = cnt_r;
            end
         end
         ST_GAP: begin
            if (CE_CPU) begin
               case (prev_r)
                  ST_SEL: begin
                     if (cmd_r.op == OP_SEL) begin
                        state_n = ST_IDLE;
                     end else if (cmd_r.op == OP_STAT) begin
                        state_n = ST_RD;
                     end else begin
                        state_n  = ST_ADDR;
                        bus_do_n = cmd_r.addr;
                     end
                  end
                  ST_ADDR: begin
                     if (cmd_r.op == OP_WR) begin
                        state_n  = ST_WR;
                        bus_do_n = cmd_r.data;
                     end else begin
                        state_n = ST_RD;
                     end
                  end
                  ST_RD: begin
                     state_n     = ST_RSP;
                     rsp_valid_n = 1'b1;
                  end
                  default: state_n = ST_IDLE;
               endcase
            end else begin
               state_n = ST_GAP;
            end
         end
         ST_RSP:  state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // FSM, shadow and output registers; reset matches the responder reset.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r     <= ST_IDLE;
         prev_r      <= ST_IDLE;
         cmd_r       <= '0;
         cnt_r       <= '0;
         bus_do_r    <= 8'h00;
         rsp_data_r  <= 8'h00;
         cur_chip_r  <= 1'b1;
         cur_stat_r  <= 1'b1;
         cur_fm_r    <= 1'b0;
         rsp_valid_r <= 1'b0;
         err_r       <= 1'b0;
         bdir_r      <= 1'b0;
         bc_r        <= 1'b0;
      end else begin
         state_r     <= state_n;
         prev_r      <= prev_n;
         cmd_r       <= cmd_n;
         cnt_r       <= cnt_n;
         bus_do_r    <= bus_do_n;
         rsp_data_r  <= rsp_data_n;
         cur_chip_r  <= cur_chip_n;
         cur_stat_r  <= cur_stat_n;
         cur_fm_r    <= cur_fm_n;
         rsp_valid_r <= rsp_valid_n;
         err_r       <= err_n;
         bdir_r      <= (state_n == ST_SEL) || (state_n == ST_ADDR) || (state_n == ST_WR);
         bc_r        <= (state_n == ST_SEL) || (state_n == ST_ADDR) || (state_n == ST_RD);
      end
   end

   assign BDIR      = bdir_r;
   assign BC        = bc_r;
   assign BUS_DO    = bus_do_r;
   assign RSP_VALID = rsp_valid_r;
   assign RSP_DATA  = rsp_data_r;
   assign ERR       = err_r;
   assign BUSY      = (state_r != ST_IDLE) || !empty_s;

endmodule
